// File: rtl/wave_ram_arbiter_pkg.sv
// wave_ram_arbiter_pkg: shared widths and the pending-write record for the wave RAM arbiter.
//   SAMPLE_ADDR_W  RAM address width (2 halves x 256 samples)
//   SAMPLE_W       sample width
//   FIFO_DEPTH     pending-write entries (power of 2, >= 2)
//   LVL_W          width of a 0..FIFO_DEPTH occupancy count
package wave_ram_arbiter_pkg;
   localparam int SAMPLE_ADDR_W = 9;
   localparam int SAMPLE_W = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   typedef logic [SAMPLE_ADDR_W-1:0] addr_t;
   typedef logic [SAMPLE_W-1:0] data_t;
   typedef struct packed {
      addr_t addr;
      data_t data;
   } wr_req_t;
endpackage

// File: rtl/wave_ram_arbiter_if.sv
// wave_ram_arbiter_if: capture, display, RAM and status signals of the wave RAM arbiter.
//   cap_we/cap_addr/cap_data    capture write strobe, address, sample
//   disp_re/disp_addr           display read strobe and address
//   disp_data/disp_valid        read data, valid one cycle after disp_re
//   ram_addr/ram_we/ram_wdata   single-port RAM command
//   ram_rdata                   RAM read data, one cycle latency
//   wr_idle/fifo_level          write path status
//   overflow/clr_overflow       sticky drop flag and its clear
// master: the clients and the RAM; slave: the arbiter.
interface wave_ram_arbiter_if;
   import wave_ram_arbiter_pkg::*;
   logic cap_we;
   addr_t cap_addr;
   data_t cap_data;
   logic disp_re;
   addr_t disp_addr;
   data_t disp_data;
   logic disp_valid;
   addr_t ram_addr;
   logic ram_we;
   data_t ram_wdata;
   data_t ram_rdata;
   logic wr_idle;
   logic [LVL_W-1:0] fifo_level;
   logic overflow;
   logic clr_overflow;
   modport master (
      output cap_we, cap_addr, cap_data, disp_re, disp_addr, ram_rdata, clr_overflow,
      input disp_data, disp_valid, ram_addr, ram_we, ram_wdata, wr_idle, fifo_level, overflow
   );
   modport slave (
      input cap_we, cap_addr, cap_data, disp_re, disp_addr, ram_rdata, clr_overflow,
      output disp_data, disp_valid, ram_addr, ram_we, ram_wdata, wr_idle, fifo_level, overflow
   );
endinterface

// File: rtl/wave_ram_arbiter_wr_fifo.sv
// wave_ram_arbiter_wr_fifo: circular buffer of parked capture writes with newest-match lookup.
//   clk, reset      clock, synchronous active-high reset (empties the buffer)
//   push_i, din_i   append an entry (caller never pushes into a full buffer without popping)
//   pop_i           drop the oldest entry
//   head_o          oldest entry
//   level_o         occupancy 0..DEPTH
//   empty_o/full_o  occupancy flags
//   look_addr_i     address searched among the valid entries
//   hit_o/hit_data_o  some entry matches; data of the newest matching entry
module wave_ram_arbiter_wr_fifo
   import wave_ram_arbiter_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input logic clk,
   input logic reset,
   input logic push_i,
   input logic pop_i,
   input wr_req_t din_i,
   input addr_t look_addr_i,
   output wr_req_t head_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic empty_o,
   output logic full_o,
   output logic hit_o,
   output data_t hit_data_o
);
   localparam int PW = $clog2(DEPTH);
   wr_req_t mem_q [DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW:0] head_q, tail_q;
   logic [PW-1:0] slot;
   always_comb begin
      level_o = tail_q - head_q;
      empty_o = level_o == '0;
      full_o = level_o == (PW+1)'(DEPTH);
      head_o = mem_q[head_q[PW-1:0]];
      hit_o = 1'b0;
      hit_data_o = '0;
      slot = '0;
      // Walk oldest to newest so a later match overrides an earlier one.
      for (int k = 0; k < DEPTH; k++) begin
         slot = head_q[PW-1:0] + PW'(k);
         if ((PW+1)'(k) < level_o && mem_q[slot].addr == look_addr_i) begin
            hit_o = 1'b1;
            hit_data_o = mem_q[slot].data;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[tail_q[PW-1:0]] <= din_i;
            tail_q <= tail_q + 1'b1;
         end
         if (pop_i) head_q <= head_q + 1'b1;
      end
   end
endmodule

// File: rtl/wave_ram_arbiter.sv
// wave_ram_arbiter: shares one single-port sample RAM between capture writes and display reads.
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    slave side of wave_ram_arbiter_if (capture, display, RAM and status signals)
// Display reads always own the RAM port; colliding capture writes are parked in a FIFO and
// drained in arrival order on read-free cycles. Reads see the newest parked data by forwarding.
module wave_ram_arbiter
   import wave_ram_arbiter_pkg::*;
(
   input logic clk,
   input logic reset,
   wave_ram_arbiter_if.slave bus
);
   logic pop, push, drop, accept, direct, we, cap_hit;
   logic empty, full, fifo_hit;
   wr_req_t head;
   data_t fifo_hit_data;
   logic [LVL_W-1:0] level;
   addr_t ram_addr_q;
   logic valid_q, fwd_hit_q, fwd_hit_d, overflow_q, overflow_d;
   data_t fwd_data_q, fwd_data_d;
   wave_ram_arbiter_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push_i(accept),
      .pop_i(pop),
      .din_i('{addr: bus.cap_addr, data: bus.cap_data}),
      .look_addr_i(bus.disp_addr),
      .head_o(head),
      .level_o(level),
      .empty_o(empty),
      .full_o(full),
      .hit_o(fifo_hit),
      .hit_data_o(fifo_hit_data)
   );
   always_comb begin
      pop = !bus.disp_re && !empty;
      // Once anything is parked, new writes queue behind it to keep RAM commits in order.
      push = bus.cap_we && (bus.disp_re || !empty);
      // A full FIFO that pops this cycle has room for the new sample.
      drop = push && full && !pop;
      accept = push && !drop;
      direct = bus.cap_we && !bus.disp_re && empty;
      we = !reset && (pop || direct);
      // A write accepted alongside the read is newer than anything already parked.
      cap_hit = accept && bus.cap_addr == bus.disp_addr;
      fwd_hit_d = bus.disp_re && (cap_hit || fifo_hit);
      fwd_data_d = cap_hit ? bus.cap_data : fifo_hit_data;
      overflow_d = drop || (overflow_q && !bus.clr_overflow);
      bus.ram_we = we;
      bus.ram_addr = reset ? '0 : bus.disp_re ? bus.disp_addr : pop ? head.addr :
                     direct ? bus.cap_addr : ram_addr_q;
      bus.ram_wdata = !we ? '0 : pop ? head.data : bus.cap_data;
      bus.wr_idle = empty && !bus.cap_we;
      bus.fifo_level = level;
      bus.overflow = overflow_q;
      bus.disp_valid = valid_q;
      bus.disp_data = !valid_q ? '0 : fwd_hit_q ? fwd_data_q : bus.ram_rdata;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_addr_q <= '0;
         valid_q <= 1'b0;
         fwd_hit_q <= 1'b0;
         fwd_data_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         ram_addr_q <= bus.ram_addr;
         valid_q <= bus.disp_re;
         fwd_hit_q <= fwd_hit_d;
         fwd_data_q <= fwd_data_d;
         overflow_q <= overflow_d;
      end
   end
endmodule

// File: tb/tb_wave_ram_arbiter.sv
// tb_wave_ram_arbiter: directed table, corner sequences and random traffic against a queue model.
module tb_wave_ram_arbiter;
   import wave_ram_arbiter_pkg::*;
   typedef struct packed {
      logic we;
      addr_t ca;
      data_t cd;
      logic re;
      addr_t da;
      logic clr;
      logic e_we;
      addr_t e_addr;
      data_t e_wd;
      logic [LVL_W-1:0] e_lvl;
      logic e_ovf;
      logic e_valid;
      data_t e_data;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   wave_ram_arbiter_if bus();
   wave_ram_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   data_t ram [1 << SAMPLE_ADDR_W];
   always @(posedge clk) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= ram[bus.ram_addr];
   end
   int n_vec = 0;
   int n_err = 0;
   wr_req_t q[$];
   data_t committed [1 << SAMPLE_ADDR_W];
   logic ovf_m, prev_re;
   data_t prev_rd;
   addr_t last_addr;
   vec_t tbl[$];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic vec_t mk(input int we, ca, cd, re, da, clr, ewe, eaddr, ewd, elvl, eovf,
                               evalid, edata);
      mk.we = 1'(we);
      mk.ca = addr_t'(ca);
      mk.cd = data_t'(cd);
      mk.re = 1'(re);
      mk.da = addr_t'(da);
      mk.clr = 1'(clr);
      mk.e_we = 1'(ewe);
      mk.e_addr = addr_t'(eaddr);
      mk.e_wd = data_t'(ewd);
      mk.e_lvl = LVL_W'(elvl);
      mk.e_ovf = 1'(eovf);
      mk.e_valid = 1'(evalid);
      mk.e_data = data_t'(edata);
   endfunction
   // Drives one cycle's inputs and checks it against the model; the caller advances the clock.
   task automatic cycle(input logic we, input addr_t ca, input data_t cd, input logic re,
                        input addr_t da, input logic clr);
      logic e_we, drop;
      addr_t e_addr;
      data_t e_wd, rd;
      wr_req_t w;
      bus.cap_we = we;
      bus.cap_addr = ca;
      bus.cap_data = cd;
      bus.disp_re = re;
      bus.disp_addr = da;
      bus.clr_overflow = clr;
      #2;
      e_we = 1'b0;
      e_addr = last_addr;
      e_wd = '0;
      drop = 1'b0;
      rd = '0;
      chk("fifo_level", 32'(bus.fifo_level), 32'(q.size()));
      chk("wr_idle", 32'(bus.wr_idle), 32'(q.size() == 0 && !we));
      chk("overflow", 32'(bus.overflow), 32'(ovf_m));
      chk("disp_valid", 32'(bus.disp_valid), 32'(prev_re));
      chk("disp_data", 32'(bus.disp_data), 32'(prev_re ? prev_rd : 8'h00));
      if (re) begin
         e_addr = da;
         if (we) begin
            if (q.size() < FIFO_DEPTH) q.push_back('{addr: ca, data: cd});
            else drop = 1'b1;
         end
         rd = committed[da];
         foreach (q[i]) if (q[i].addr == da) rd = q[i].data;
      end else if (q.size() != 0) begin
         w = q.pop_front();
         e_we = 1'b1;
         e_addr = w.addr;
         e_wd = w.data;
         committed[w.addr] = w.data;
         if (we) q.push_back('{addr: ca, data: cd});
      end else if (we) begin
         e_we = 1'b1;
         e_addr = ca;
         e_wd = cd;
         committed[ca] = cd;
      end
      chk("ram_we", 32'(bus.ram_we), 32'(e_we));
      chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
      if (e_we) chk("ram_wdata", 32'(bus.ram_wdata), 32'(e_wd));
      ovf_m = drop || (ovf_m && !clr);
      prev_re = re;
      prev_rd = rd;
      last_addr = e_addr;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      bus.cap_we = 1'b0;
      bus.disp_re = 1'b0;
      bus.clr_overflow = 1'b0;
      bus.cap_addr = '0;
      bus.cap_data = '0;
      bus.disp_addr = '0;
      #2;
      chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      ovf_m = 1'b0;
      prev_re = 1'b0;
      prev_rd = '0;
      last_addr = '0;
   endtask
   initial begin
      vec_t v;
      for (int i = 0; i < (1 << SAMPLE_ADDR_W); i++) ram[i] = data_t'($urandom);
      ram[9'h010] = 8'h3C;
      foreach (ram[i]) committed[i] = ram[i];
      //           we ca     cd    re da     clr  ewe eaddr  ewd   lvl ovf vld data
      tbl.push_back(mk(1, 'h005, 'hA5, 0, 'h000, 0,  1, 'h005, 'hA5, 0, 0, 0, 'h00));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  0, 'h005, 'h00, 0, 0, 0, 'h00));
      tbl.push_back(mk(0, 'h000, 'h00, 1, 'h010, 0,  0, 'h010, 'h00, 0, 0, 0, 'h00));
      tbl.push_back(mk(1, 'h001, 'h11, 1, 'h010, 0,  0, 'h010, 'h00, 0, 0, 1, 'h3C));
      tbl.push_back(mk(1, 'h002, 'h22, 1, 'h010, 0,  0, 'h010, 'h00, 1, 0, 1, 'h3C));
      tbl.push_back(mk(1, 'h003, 'h33, 1, 'h010, 0,  0, 'h010, 'h00, 2, 0, 1, 'h3C));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  1, 'h001, 'h11, 3, 0, 1, 'h3C));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  1, 'h002, 'h22, 2, 0, 0, 'h00));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  1, 'h003, 'h33, 1, 0, 0, 'h00));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  0, 'h003, 'h00, 0, 0, 0, 'h00));
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(1, 'h100 + k, 'h40 + k, 1, 'h010, 0, 0, 'h010, 'h00, k, 0, k != 0,
                          k != 0 ? 'h3C : 'h00));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 1,  1, 'h100, 'h40, 4, 1, 1, 'h3C));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  1, 'h101, 'h41, 3, 0, 0, 'h00));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  1, 'h102, 'h42, 2, 0, 0, 'h00));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  1, 'h103, 'h43, 1, 0, 0, 'h00));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  0, 'h103, 'h00, 0, 0, 0, 'h00));
      tbl.push_back(mk(1, 'h020, 'hAA, 1, 'h010, 0,  0, 'h010, 'h00, 0, 0, 0, 'h00));
      tbl.push_back(mk(1, 'h020, 'hBB, 1, 'h010, 0,  0, 'h010, 'h00, 1, 0, 1, 'h3C));
      tbl.push_back(mk(0, 'h000, 'h00, 1, 'h020, 0,  0, 'h020, 'h00, 2, 0, 1, 'h3C));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  1, 'h020, 'hAA, 2, 0, 1, 'hBB));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  1, 'h020, 'hBB, 1, 0, 0, 'h00));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  0, 'h020, 'h00, 0, 0, 0, 'h00));
      tbl.push_back(mk(1, 'h030, 'h77, 1, 'h030, 0,  0, 'h030, 'h00, 0, 0, 0, 'h00));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  1, 'h030, 'h77, 1, 0, 1, 'h77));
      tbl.push_back(mk(0, 'h000, 'h00, 0, 'h000, 0,  0, 'h030, 'h00, 0, 0, 0, 'h00));
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         cycle(v.we, v.ca, v.cd, v.re, v.da, v.clr);
         chk($sformatf("tbl%0d_ram_we", i), 32'(bus.ram_we), 32'(v.e_we));
         chk($sformatf("tbl%0d_ram_addr", i), 32'(bus.ram_addr), 32'(v.e_addr));
         if (v.e_we) chk($sformatf("tbl%0d_ram_wdata", i), 32'(bus.ram_wdata), 32'(v.e_wd));
         chk($sformatf("tbl%0d_level", i), 32'(bus.fifo_level), 32'(v.e_lvl));
         chk($sformatf("tbl%0d_overflow", i), 32'(bus.overflow), 32'(v.e_ovf));
         chk($sformatf("tbl%0d_disp_valid", i), 32'(bus.disp_valid), 32'(v.e_valid));
         chk($sformatf("tbl%0d_disp_data", i), 32'(bus.disp_data), 32'(v.e_data));
         @(negedge clk);
      end
      // Reset while two writes are parked: they must never reach the RAM.
      cycle(1'b1, 9'h040, 8'h01, 1'b1, 9'h010, 1'b0);
      @(negedge clk);
      cycle(1'b1, 9'h041, 8'h02, 1'b1, 9'h010, 1'b0);
      @(negedge clk);
      #2;
      chk("t6_level_before_reset", 32'(bus.fifo_level), 32'd2);
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
         chk("t6_no_ram_we", 32'(bus.ram_we), 32'h0);
         chk("t6_level", 32'(bus.fifo_level), 32'h0);
         @(negedge clk);
      end
      // Drop and clear in the same cycle: the set wins.
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 9'h050 + 9'(k), 8'h60 + 8'(k), 1'b1, 9'h050, k == 4);
         @(negedge clk);
      end
      cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
      chk("set_wins_overflow", 32'(bus.overflow), 32'h1);
      @(negedge clk);
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 249) == 0) do_reset();
         cycle($urandom_range(0, 99) < 60, 9'h1F0 | 9'($urandom_range(0, 7)), data_t'($urandom),
               $urandom_range(0, 99) < 55, 9'h1F0 | 9'($urandom_range(0, 7)),
               $urandom_range(0, 99) < 8);
         @(negedge clk);
      end
      while (q.size() != 0) begin
         cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
         @(negedge clk);
      end
      for (int a = 9'h1F0; a < 9'h1F8; a++) chk("final_ram", 32'(ram[a]), 32'(committed[a]));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
